// File: rtl/calc_entry_sequencer.sv
// calc_entry_sequencer: calculator entry front end.
// Synchronizes and debounces the ENTER/CLEAR buttons, turns each debounced press into a
// one-cycle event, and steps an IDLE -> COLLECT -> DONE sequencer that captures the
// operand/sign/operation switches and issues a one-cycle step strobe per accepted entry.
// Optional feature macro: CALC_DIVZERO_GUARD_EN (refuse divide-by-zero entries in COLLECT).
module calc_entry_sequencer #(
    parameter int DEB_CYCLES = 16,
    parameter int N_OPS      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enter_btn,
    input  logic       clear_btn,
    input  logic [1:0] sw_num,
    input  logic       sw_sign,
    input  logic [1:0] sw_op,
    output logic [1:0] out_num,
    output logic       out_sign,
    output logic [1:0] out_op,
    output logic       step,
    output logic       first_entry,
    output logic [2:0] entry_idx,
    output logic       done,
    output logic       reject
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    // Button lanes: bit 0 = ENTER, bit 1 = CLEAR
    logic [1:0]    w_raw;
    logic [1:0]    r_sync1;
    logic [1:0]    r_sync2;
    logic [1:0]    r_lvl;
    logic [1:0]    r_lvl_d;
    logic [CW-1:0] r_cnt [2];
    logic [1:0]    w_ev;
    logic          w_ent_ev;
    logic          w_clr_ev;
    logic          w_divzero;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [1:0]    r_num;
    logic [1:0]    r_op;
    logic          r_sign;
    logic          r_step;
    logic          r_first;
    logic          r_reject;
    logic [2:0]    r_idx;
    logic [2:0]    w_idx_nxt;
    logic [2:0]    w_idx_inc;
    logic          w_cap;
    logic          w_step_nxt;
    logic          w_first_nxt;
    logic          w_rej_nxt;

    assign w_raw    = {clear_btn, enter_btn};
    assign w_ev     = r_lvl & ~r_lvl_d;
    assign w_ent_ev = w_ev[0];
    assign w_clr_ev = w_ev[1];

`ifdef CALC_DIVZERO_GUARD_EN
    assign w_divzero = (sw_op == 2'b10) && (sw_num == 2'b00);
`else
    assign w_divzero = 1'b0;
`endif

    // Two-flop synchronizer, debounce counter and level, plus delayed level for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_lvl   <= '0;
            r_lvl_d <= '0;
            for (int i = 0; i < 2; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_lvl_d <= r_lvl;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] != r_lvl[i]) begin
                    // Level flips once the disagreement has lasted DEB_CYCLES samples
                    if (r_cnt[i] == CW'(DEB_CYCLES - 1)) begin
                        r_lvl[i] <= ~r_lvl[i];
                        r_cnt[i] <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + CW'(1);
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    // Sequencer state and held entry registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_num    <= '0;
            r_op     <= '0;
            r_sign   <= 1'b1;
            r_step   <= 1'b0;
            r_first  <= 1'b0;
            r_reject <= 1'b0;
            r_idx    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_step   <= w_step_nxt;
            r_first  <= w_first_nxt;
            r_reject <= w_rej_nxt;
            if (w_cap) begin
                r_num  <= sw_num;
                r_sign <= sw_sign;
                r_op   <= sw_op;
            end
        end
    end

    // Next-state and strobe decode; CLEAR has priority over a simultaneous ENTER
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_idx_inc   = r_idx + 3'd1;
        w_cap       = 1'b0;
        w_step_nxt  = 1'b0;
        w_first_nxt = 1'b0;
        w_rej_nxt   = 1'b0;
        if (w_clr_ev) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = '0;
        end else if (w_ent_ev) begin
            case (r_state)
                S_IDLE: begin
                    w_cap       = 1'b1;
                    w_step_nxt  = 1'b1;
                    w_first_nxt = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = (N_OPS == 0) ? S_DONE : S_COLLECT;
                end
                S_COLLECT: begin
                    if (w_divzero) begin
                        w_rej_nxt = 1'b1;
                    end else begin
                        w_cap      = 1'b1;
                        w_step_nxt = 1'b1;
                        w_idx_nxt  = w_idx_inc;
                        if (w_idx_inc == 3'(N_OPS)) begin
                            w_state_nxt = S_DONE;
                        end
                    end
                end
                default: begin
                    // DONE ignores ENTER entirely
                end
            endcase
        end
    end

    assign out_num     = r_num;
    assign out_sign    = r_sign;
    assign out_op      = r_op;
    assign step        = r_step;
    assign first_entry = r_first;
    assign entry_idx   = r_idx;
    assign done        = (r_state == S_DONE);
    assign reject      = r_reject;

endmodule
